// File: rtl/rv_mem_arbiter_pkg.sv
// Shared constants and payload types for the uRV fetch/data memory arbiter.
package rv_mem_arbiter_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned MEM_RD_LAT = 1;
  localparam int unsigned STARVE_W   = 4;

  // Per-grant response flags, delayed by the memory read latency.
  typedef struct packed {
    logic im_valid;
    logic ld_done;
    logic st_done;
  } resp_t;

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Fetch port, data port and memory port of the arbiter bundled as one interface.
interface rv_mem_arbiter_if;
  import rv_mem_arbiter_pkg::*;

  logic [ADDR_W-1:0] im_addr_i;
  logic [DATA_W-1:0] im_data_o;
  logic              im_valid_o;

  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_data_i;
  logic [BE_W-1:0]   dm_data_select_i;
  logic              dm_load_i;
  logic              dm_store_i;
  logic              dm_ready_o;
  logic [DATA_W-1:0] dm_load_data_o;
  logic              dm_load_done_o;
  logic              dm_store_done_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_bwe_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  im_addr_i, dm_addr_i, dm_data_i, dm_data_select_i, dm_load_i, dm_store_i,
           mem_rdata_i,
    output im_data_o, im_valid_o, dm_ready_o, dm_load_data_o, dm_load_done_o,
           dm_store_done_o, mem_addr_o, mem_wdata_o, mem_bwe_o
  );

  // Core and memory side.
  modport master (
    output im_addr_i, dm_addr_i, dm_data_i, dm_data_select_i, dm_load_i, dm_store_i,
           mem_rdata_i,
    input  im_data_o, im_valid_o, dm_ready_o, dm_load_data_o, dm_load_done_o,
           dm_store_done_o, mem_addr_o, mem_wdata_o, mem_bwe_o
  );

endinterface

// File: rtl/rv_mem_arbiter.sv
// Shares one single-ported synchronous RAM between uRV fetch and load/store.
// Data wins arbitration; a starvation counter forces a fetch grant every MAX_STARVE data grants.
module rv_mem_arbiter
  import rv_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rv_mem_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);
  localparam int unsigned         RESP_W     = MEM_RD_LAT * $bits(resp_t);

  logic                dreq_c;
  logic                gnt_d_c;
  logic                gnt_f_c;
  resp_t               resp_new_c;
  logic [STARVE_W-1:0] starve_cnt_d, starve_cnt_q;
  resp_t [MEM_RD_LAT-1:0] resp_d, resp_q;

  // Grant decision: data unless fetch has waited the maximum, nothing in reset.
  always_comb begin
    dreq_c  = bus.dm_load_i | bus.dm_store_i;
    gnt_d_c = dreq_c & ~rst_i & (starve_cnt_q != STARVE_LIM);
    gnt_f_c = ~gnt_d_c & ~rst_i;
  end

  // Starvation count and response flags that line up with the memory read data.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt_f_c) begin
      starve_cnt_d = '0;
    end else if (gnt_d_c) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
    resp_new_c = '{im_valid: gnt_f_c,
                   ld_done:  gnt_d_c & ~bus.dm_store_i,
                   st_done:  gnt_d_c &  bus.dm_store_i};
    resp_d = RESP_W'({resp_q, resp_new_c});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      resp_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_q       <= resp_d;
    end
  end

  assign bus.dm_ready_o      = gnt_d_c;
  assign bus.mem_addr_o      = gnt_d_c ? bus.dm_addr_i : bus.im_addr_i;
  assign bus.mem_bwe_o       = (gnt_d_c & bus.dm_store_i) ? bus.dm_data_select_i : '0;
  assign bus.mem_wdata_o     = bus.dm_data_i;
  assign bus.im_data_o       = bus.mem_rdata_i;
  assign bus.dm_load_data_o  = bus.mem_rdata_i;
  assign bus.im_valid_o      = resp_q[MEM_RD_LAT-1].im_valid;
  assign bus.dm_load_done_o  = resp_q[MEM_RD_LAT-1].ld_done;
  assign bus.dm_store_done_o = resp_q[MEM_RD_LAT-1].st_done;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant count since last fetch, word-array memory image).
module tb_rv_mem_arbiter;

  localparam int unsigned MAX_ST = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  rv_mem_arbiter_if bus ();

  rv_mem_arbiter #(.MAX_STARVE(MAX_ST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous RAM, 256 words; preload port used only while in reset.
  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin : ram
    logic [31:0] w;
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else begin
      w = mem[bus.mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_bwe_o[b]) w[b*8 +: 8] = bus.mem_wdata_o[b*8 +: 8];
      mem[bus.mem_addr_o[9:2]] <= w;
      bus.mem_rdata_i <= w;
    end
  end

  // Stimulus and reference model state.
  logic        s_rst, s_ld, s_st;
  logic [31:0] s_daddr, s_ddata, s_iaddr;
  logic [3:0]  s_sel;
  logic [31:0] ref_mem [256];
  int          waits;
  logic        e_gd;
  logic [31:0] e_maddr;
  logic [3:0]  e_bwe;
  logic        nx_iv, nx_ld, nx_st;
  logic [31:0] nx_idata, nx_ldata;

  function automatic logic [31:0] init_word(input int i);
    return {8'(i), 8'hA5, ~8'(i), 8'h3C};
  endfunction

  task automatic apply();
    rst                  = s_rst;
    bus.dm_load_i        = s_ld;
    bus.dm_store_i       = s_st;
    bus.dm_addr_i        = s_daddr;
    bus.dm_data_i        = s_ddata;
    bus.dm_data_select_i = s_sel;
    bus.im_addr_i        = s_iaddr;
    #1;
  endtask

  // Model: data wins unless fetch has already lost MAX_ST times in a row.
  task automatic model_step();
    logic [7:0] di;
    di = s_daddr[9:2];
    nx_iv = 1'b0; nx_ld = 1'b0; nx_st = 1'b0;
    e_gd = 1'b0; e_bwe = 4'b0; e_maddr = s_iaddr;
    if (s_rst) begin
      waits = 0;
    end else if ((s_ld || s_st) && waits < int'(MAX_ST)) begin
      e_gd = 1'b1;
      waits++;
      e_maddr = s_daddr;
      if (s_st) begin
        e_bwe = s_sel;
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) ref_mem[di][b*8 +: 8] = s_ddata[b*8 +: 8];
        nx_st = 1'b1;
      end else begin
        nx_ld    = 1'b1;
        nx_ldata = ref_mem[di];
      end
    end else begin
      waits    = 0;
      nx_iv    = 1'b1;
      nx_idata = ref_mem[s_iaddr[9:2]];
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    ref_mem[idx] = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic idle_cycle();
    s_ld = 1'b0; s_st = 1'b0; s_rst = 1'b0;
    apply(); model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; s_ld = 1'b1; s_st = 1'b1; s_sel = 4'hF;
    s_daddr = 32'h10; s_ddata = 32'hFFFF_FFFF; s_iaddr = 32'h0;
    apply(); model_step();
    n_total++; if (bus.dm_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", bus.dm_ready_o); end
    n_total++; if (bus.mem_bwe_o !== 4'b0) begin n_bad++; $display("FAIL reset_bwe got=%b exp=0000", bus.mem_bwe_o); end
    @(posedge clk); #1;
    n_total++;
    if ({bus.im_valid_o, bus.dm_load_done_o, bus.dm_store_done_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=000", {bus.im_valid_o, bus.dm_load_done_o, bus.dm_store_done_o});
    end
    s_rst = 1'b0; s_ld = 1'b0; s_st = 1'b0;
    apply(); model_step();
    n_total++; if (bus.dm_ready_o !== 1'b0) begin n_bad++; $display("FAIL release_ready got=%b exp=0", bus.dm_ready_o); end
    @(posedge clk); #1;
    n_total++; if (bus.im_valid_o !== 1'b1) begin n_bad++; $display("FAIL release_fetch got=%b exp=1", bus.im_valid_o); end
    n_total++; if (bus.im_data_o !== init_word(0)) begin n_bad++; $display("FAIL release_idata got=%h exp=%h", bus.im_data_o, init_word(0)); end
  endtask

  task automatic test_fetch_only();
    s_ld = 1'b0; s_st = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_iaddr = 32'(4 * k);
      apply(); model_step();
      n_total++; if (bus.mem_addr_o !== s_iaddr) begin n_bad++; $display("FAIL fetch_addr got=%h exp=%h", bus.mem_addr_o, s_iaddr); end
      @(posedge clk); #1;
      n_total++; if (bus.im_valid_o !== 1'b1) begin n_bad++; $display("FAIL fetch_valid k=%0d got=%b exp=1", k, bus.im_valid_o); end
      n_total++; if (bus.im_data_o !== init_word(k)) begin n_bad++; $display("FAIL fetch_data k=%0d got=%h exp=%h", k, bus.im_data_o, init_word(k)); end
    end
  endtask

  task automatic test_single_load();
    s_ld = 1'b1; s_st = 1'b0; s_daddr = 32'h100;
    apply(); model_step();
    n_total++; if (bus.dm_ready_o !== 1'b1) begin n_bad++; $display("FAIL load_ready got=%b exp=1", bus.dm_ready_o); end
    n_total++; if (bus.mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL load_addr got=%h exp=00000100", bus.mem_addr_o); end
    @(posedge clk); #1;
    n_total++; if (bus.dm_load_done_o !== 1'b1) begin n_bad++; $display("FAIL load_done got=%b exp=1", bus.dm_load_done_o); end
    n_total++; if (bus.dm_load_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data got=%h exp=deadbeef", bus.dm_load_data_o); end
    n_total++; if (bus.im_valid_o !== 1'b0) begin n_bad++; $display("FAIL load_ivalid got=%b exp=0", bus.im_valid_o); end
  endtask

  task automatic test_byte_store();
    s_ld = 1'b0; s_st = 1'b1; s_sel = 4'b0010; s_ddata = 32'h0000AB00; s_daddr = 32'h200;
    apply(); model_step();
    n_total++; if (bus.mem_bwe_o !== 4'b0010) begin n_bad++; $display("FAIL store_bwe got=%b exp=0010", bus.mem_bwe_o); end
    n_total++; if (bus.mem_wdata_o !== 32'h0000AB00) begin n_bad++; $display("FAIL store_wdata got=%h exp=0000ab00", bus.mem_wdata_o); end
    @(posedge clk); #1;
    n_total++; if (bus.dm_store_done_o !== 1'b1) begin n_bad++; $display("FAIL store_done got=%b exp=1", bus.dm_store_done_o); end
    n_total++; if (bus.dm_load_done_o !== 1'b0) begin n_bad++; $display("FAIL store_lddone got=%b exp=0", bus.dm_load_done_o); end
    s_st = 1'b0; s_ld = 1'b1;
    apply(); model_step();
    n_total++; if (bus.mem_bwe_o !== 4'b0) begin n_bad++; $display("FAIL reload_bwe got=%b exp=0000", bus.mem_bwe_o); end
    @(posedge clk); #1;
    n_total++; if (bus.dm_load_data_o !== 32'h1122AB44) begin n_bad++; $display("FAIL store_readback got=%h exp=1122ab44", bus.dm_load_data_o); end
  endtask

  task automatic test_starvation();
    logic [9:0] pat;
    pat = 10'b0111101111;  // bit i = data granted in cycle i
    idle_cycle();
    s_ld = 1'b1; s_st = 1'b0; s_daddr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      apply(); model_step();
      n_total++; if (bus.dm_ready_o !== pat[i]) begin n_bad++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", i, bus.dm_ready_o, pat[i]); end
      @(posedge clk); #1;
      n_total++; if (bus.im_valid_o !== ~pat[i]) begin n_bad++; $display("FAIL starve_ivalid cyc=%0d got=%b exp=%b", i, bus.im_valid_o, ~pat[i]); end
    end
    s_ld = 1'b0;
  endtask

  task automatic test_load_store_both();
    s_ld = 1'b1; s_st = 1'b1; s_sel = 4'b0001; s_ddata = 32'h000000C7; s_daddr = 32'h104;
    apply(); model_step();
    n_total++; if (bus.mem_bwe_o !== 4'b0001) begin n_bad++; $display("FAIL both_bwe got=%b exp=0001", bus.mem_bwe_o); end
    @(posedge clk); #1;
    n_total++; if (bus.dm_store_done_o !== 1'b1) begin n_bad++; $display("FAIL both_stdone got=%b exp=1", bus.dm_store_done_o); end
    n_total++; if (bus.dm_load_done_o !== 1'b0) begin n_bad++; $display("FAIL both_lddone got=%b exp=0", bus.dm_load_done_o); end
    s_st = 1'b0;
    apply(); model_step();
    @(posedge clk); #1;
    n_total++; if (bus.dm_load_data_o !== 32'h41A5BEC7) begin n_bad++; $display("FAIL both_readback got=%h exp=41a5bec7", bus.dm_load_data_o); end
    s_ld = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle_cycle();
    s_ld = 1'b1; s_st = 1'b0; s_daddr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      apply(); model_step();
      @(posedge clk); #1;
    end
    s_rst = 1'b1; s_st = 1'b1; s_sel = 4'hF;
    apply(); model_step();
    n_total++; if (bus.dm_ready_o !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got=%b exp=0", bus.dm_ready_o); end
    n_total++; if (bus.mem_bwe_o !== 4'b0) begin n_bad++; $display("FAIL midrst_bwe got=%b exp=0000", bus.mem_bwe_o); end
    @(posedge clk); #1;
    n_total++; if (bus.dm_load_done_o !== 1'b0) begin n_bad++; $display("FAIL midrst_lddone got=%b exp=0", bus.dm_load_done_o); end
    n_total++; if (bus.dm_store_done_o !== 1'b0) begin n_bad++; $display("FAIL midrst_stdone got=%b exp=0", bus.dm_store_done_o); end
    apply(); model_step();
    @(posedge clk); #1;
    s_rst = 1'b0; s_st = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(); model_step();
      n_total++; if (bus.dm_ready_o !== (i < 4)) begin n_bad++; $display("FAIL midrst_cnt cyc=%0d got=%b exp=%b", i, bus.dm_ready_o, (i < 4)); end
      @(posedge clk); #1;
    end
    s_ld = 1'b0;
  endtask

  task automatic test_random();
    logic pend;
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      s_rst = ($urandom_range(0, 63) == 0);
      if (!pend) begin
        if ($urandom_range(0, 2) != 0) begin
          pend    = 1'b1;
          s_ld    = 1'($urandom_range(0, 1));
          s_st    = 1'($urandom_range(0, 1));
          if (!s_ld && !s_st) s_ld = 1'b1;
          s_daddr = {22'b0, 8'($urandom_range(0, 31)), 2'b00};
          s_ddata = $urandom;
          s_sel   = 4'($urandom);
        end else begin
          s_ld = 1'b0; s_st = 1'b0;
        end
      end
      apply(); model_step();
      n_total++; if (bus.dm_ready_o !== e_gd) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.dm_ready_o, e_gd); end
      n_total++; if (bus.mem_bwe_o !== e_bwe) begin n_bad++; $display("FAIL rnd_bwe cyc=%0d got=%b exp=%b", c, bus.mem_bwe_o, e_bwe); end
      n_total++; if (bus.mem_addr_o !== e_maddr) begin n_bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, bus.mem_addr_o, e_maddr); end
      if (e_gd || s_rst) pend = 1'b0;
      if (nx_iv) s_iaddr = (s_iaddr + 32'd4) & 32'h3FC;
      @(posedge clk); #1;
      n_total++;
      if ({bus.im_valid_o, bus.dm_load_done_o, bus.dm_store_done_o} !== {nx_iv, nx_ld, nx_st}) begin
        n_bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c,
                          {bus.im_valid_o, bus.dm_load_done_o, bus.dm_store_done_o}, {nx_iv, nx_ld, nx_st});
      end
      if (nx_iv) begin
        n_total++; if (bus.im_data_o !== nx_idata) begin n_bad++; $display("FAIL rnd_idata cyc=%0d got=%h exp=%h", c, bus.im_data_o, nx_idata); end
      end
      if (nx_ld) begin
        n_total++; if (bus.dm_load_data_o !== nx_ldata) begin n_bad++; $display("FAIL rnd_ldata cyc=%0d got=%h exp=%h", c, bus.dm_load_data_o, nx_ldata); end
      end
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0; waits = 0;
    pre_we = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
    s_rst = 1'b1; s_ld = 1'b0; s_st = 1'b0; s_sel = 4'h0;
    s_daddr = 32'h0; s_ddata = 32'h0; s_iaddr = 32'h0;
    nx_iv = 1'b0; nx_ld = 1'b0; nx_st = 1'b0; nx_idata = 32'h0; nx_ldata = 32'h0;
    apply();
    for (int i = 0; i < 256; i++) preload(8'(i), init_word(i));
    preload(8'h40, 32'hDEADBEEF);
    preload(8'h80, 32'h11223344);
    test_reset();
    test_fetch_only();
    test_single_load();
    test_byte_store();
    test_starvation();
    test_load_store_both();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
